// File: rtl/cache_op_fsm.sv
// CACHE-instruction sequencer: reads/writes the I/D tag arrays for one maintenance
// request, issues a dirty-line writeback when needed, and stalls WB until retire.
package cache_op_pkg;
    // {operation[2:0], cache[1:0]} as encoded in the CACHE instruction; cache 0 = I, 1 = D
    typedef enum logic [4:0] {
        I_Index_Invalidate        = 5'b000_00,
        D_Index_Writeback_Invalid = 5'b000_01,
        I_Index_Load_Tag          = 5'b001_00,
        I_Index_Store_Tag         = 5'b010_00,
        D_Index_Store_Tag         = 5'b010_01,
        I_Hit_Invalid             = 5'b100_00,
        D_Hit_Invalid             = 5'b100_01,
        D_Hit_Writeback_Invalid   = 5'b101_01
    } CacheCodeType;
endpackage

module cache_op_fsm
    import cache_op_pkg::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned TAG_W = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  CacheCodeType                  req_op,
    input  logic [TAG_W-1:0]              req_tag,
    input  logic                          req_v,
    input  logic                          req_d,
    input  logic [7:0]                    req_index,
    input  logic [1:0]                    req_way,
    output logic                          busy,
    output logic                          done,
    output logic                          tag_sel,
    output logic [7:0]                    tag_addr,
    input  logic [WAYS-1:0][TAG_W+1:0]    tag_rdata,
    output logic [WAYS-1:0]               tag_we,
    output logic [TAG_W+1:0]              tag_wdata,
    output logic                          wb_req,
    output logic [31:0]                   wb_addr,
    output logic [1:0]                    wb_way,
    input  logic                          wb_done
);

    typedef enum logic [2:0] {
        IDLE, READ, CHECK, WRITEBACK, UPDATE, DONE
    } state_t;

    state_t           state_q, state_d;
    CacheCodeType     op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             v_q, v_d;
    logic             d_q, d_d;
    logic [7:0]       index_q, index_d;
    logic [1:0]       way_q, way_d;
    logic             sel_q, sel_d;
    logic [1:0]       tgt_way_q, tgt_way_d;
    logic [TAG_W-1:0] tgt_tag_q, tgt_tag_d;

    logic             is_hit_op, is_wb_op, is_store_op;
    logic             hit;
    logic [1:0]       hit_way;
    logic [1:0]       chk_way;
    logic [TAG_W+1:0] chk_line;

    assign is_hit_op   = op_q inside {I_Hit_Invalid, D_Hit_Invalid, D_Hit_Writeback_Invalid};
    assign is_wb_op    = op_q inside {D_Index_Writeback_Invalid, D_Hit_Writeback_Invalid};
    assign is_store_op = op_q inside {I_Index_Store_Tag, D_Index_Store_Tag};

    // Lowest-numbered valid way whose tag matches wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && tag_rdata[w][TAG_W+1] && tag_rdata[w][TAG_W-1:0] == tag_q) begin
                hit     = 1'b1;
                hit_way = w[1:0];
            end
        end
    end

    assign chk_way  = is_hit_op ? hit_way : way_q;
    assign chk_line = tag_rdata[chk_way];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= I_Index_Invalidate;
            tag_q     <= '0;
            v_q       <= 1'b0;
            d_q       <= 1'b0;
            index_q   <= '0;
            way_q     <= '0;
            sel_q     <= 1'b0;
            tgt_way_q <= '0;
            tgt_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            v_q       <= v_d;
            d_q       <= d_d;
            index_q   <= index_d;
            way_q     <= way_d;
            sel_q     <= sel_d;
            tgt_way_q <= tgt_way_d;
            tgt_tag_q <= tgt_tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        v_d       = v_q;
        d_d       = d_q;
        index_d   = index_q;
        way_d     = way_q;
        sel_d     = sel_q;
        tgt_way_d = tgt_way_q;
        tgt_tag_d = tgt_tag_q;
        tag_we    = '0;
        tag_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    tag_d   = req_tag;
                    v_d     = req_v;
                    d_d     = req_d;
                    index_d = req_index;
                    way_d   = req_way;
                    sel_d   = req_op[0];
                    case (req_op)
                        I_Index_Store_Tag, D_Index_Store_Tag:            state_d = UPDATE;
                        I_Index_Invalidate, D_Index_Writeback_Invalid,
                        I_Hit_Invalid, D_Hit_Invalid,
                        D_Hit_Writeback_Invalid:                         state_d = READ;
                        default:                                         state_d = DONE;
                    endcase
                end
            end
            READ:  state_d = CHECK;
            CHECK: begin
                // Victim tag comes from the RAM so Index-op writebacks use the stored line address
                tgt_way_d = chk_way;
                tgt_tag_d = chk_line[TAG_W-1:0];
                if (is_hit_op && !hit)
                    state_d = DONE;
                else if (is_wb_op && chk_line[TAG_W+1] && chk_line[TAG_W])
                    state_d = WRITEBACK;
                else
                    state_d = UPDATE;
            end
            WRITEBACK: begin
                if (wb_done)
                    state_d = UPDATE;
            end
            UPDATE: begin
                if (is_store_op) begin
                    tag_we[way_q] = 1'b1;
                    tag_wdata     = {v_q, d_q, tag_q};
                end else begin
                    tag_we[tgt_way_q] = 1'b1;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready || req_valid;
    assign done      = (state_q == DONE);
    assign wb_req    = (state_q == WRITEBACK);
    assign tag_sel   = sel_q;
    assign tag_addr  = index_q;
    assign wb_addr   = {tgt_tag_q, index_q, 4'b0000};
    assign wb_way    = tgt_way_q;

endmodule

// File: tb/tb_cache_op_fsm.sv
// Directed bench for cache_op_fsm with a read-only synchronous tag RAM model.
module tb_cache_op_fsm;
    import cache_op_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    CacheCodeType       req_op;
    logic [19:0]        req_tag;
    logic               req_v;
    logic               req_d;
    logic [7:0]         req_index;
    logic [1:0]         req_way;
    logic               busy;
    logic               done;
    logic               tag_sel;
    logic [7:0]         tag_addr;
    logic [3:0][21:0]   tag_rdata;
    logic [3:0]         tag_we;
    logic [21:0]        tag_wdata;
    logic               wb_req;
    logic [31:0]        wb_addr;
    logic [1:0]         wb_way;
    logic               wb_done;

    logic [3:0][21:0]   imem [256];
    logic [3:0][21:0]   dmem [256];

    int unsigned tests = 0;
    int unsigned fails = 0;

    cache_op_fsm #(.WAYS(4), .TAG_W(20)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_v(req_v), .req_d(req_d),
        .req_index(req_index), .req_way(req_way),
        .busy(busy), .done(done),
        .tag_sel(tag_sel), .tag_addr(tag_addr), .tag_rdata(tag_rdata),
        .tag_we(tag_we), .tag_wdata(tag_wdata),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_way(wb_way), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        tag_rdata <= tag_sel ? dmem[tag_addr] : imem[tag_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic request(input CacheCodeType op, input logic [7:0] idx, input logic [1:0] way,
                           input logic [19:0] tag, input logic v, input logic d);
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        req_way   = way;
        req_tag   = tag;
        req_v     = v;
        req_d     = d;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = I_Index_Invalidate; req_tag = '0;
        req_v = 1'b0; req_d = 1'b0; req_index = '0; req_way = '0; wb_done = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end
        imem[8'h55][0] = {1'b1, 1'b0, 20'h11111};
        imem[8'h55][1] = {1'b1, 1'b0, 20'h12345};
        imem[8'h55][2] = {1'b0, 1'b0, 20'h12345};
        imem[8'h55][3] = {1'b1, 1'b1, 20'h12345};
        dmem[8'h10][0] = {1'b1, 1'b1, 20'h00400};
        dmem[8'h10][1] = {1'b1, 1'b1, 20'h00401};
        dmem[8'h10][3] = {1'b1, 1'b0, 20'h00400};
        dmem[8'h20][0] = {1'b1, 1'b0, 20'h11111};
        dmem[8'h20][1] = {1'b1, 1'b1, 20'h22222};
        dmem[8'h20][2] = {1'b0, 1'b1, 20'h77777};
        dmem[8'h20][3] = {1'b1, 1'b0, 20'h33333};
        dmem[8'h30][0] = {1'b1, 1'b1, 20'h0BEEF};
        dmem[8'h30][1] = {1'b1, 1'b0, 20'h0BEEF};
        dmem[8'h40][3] = {1'b1, 1'b1, 20'hCAFE0};

        tick(); tick();
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tag_we", tag_we, 0);
        check("rst_wb_req", wb_req, 0);
        check("rst_tag_sel", tag_sel, 0);
        check("rst_tag_addr", tag_addr, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_way", wb_way, 0);
        reset = 1'b0;
        tick();

        // D_Index_Store_Tag; inputs scrambled after accept must not matter
        request(D_Index_Store_Tag, 8'h3A, 2'd2, 20'hABCDE, 1'b1, 1'b0);
        check("st_accept_busy", busy, 1);
        check("st_accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0; req_tag = 20'h55555; req_way = 2'd0; req_v = 1'b0;
        #1;
        check("st_we", tag_we, 4'b0100);
        check("st_wdata", tag_wdata, 22'h2ABCDE);
        check("st_addr", tag_addr, 8'h3A);
        check("st_sel", tag_sel, 1);
        check("st_ready_low", req_ready, 0);
        check("st_done_early", done, 0);
        tick();
        check("st_done", done, 1);
        check("st_done_busy", busy, 1);
        check("st_done_we", tag_we, 0);
        tick();
        check("st_idle_ready", req_ready, 1);
        check("st_idle_busy", busy, 0);
        check("st_idle_done", done, 0);

        // I_Hit_Invalid: ways 1 and 3 match, way 1 wins
        request(I_Hit_Invalid, 8'h55, 2'd3, 20'h12345, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        #1;
        check("ihit_addr", tag_addr, 8'h55);
        check("ihit_sel", tag_sel, 0);
        check("ihit_we_t1", tag_we, 0);
        tick();
        check("ihit_we_t2", tag_we, 0);
        check("ihit_done_t2", done, 0);
        tick();
        check("ihit_we", tag_we, 4'b0010);
        check("ihit_wdata", tag_wdata, 0);
        check("ihit_wb_req", wb_req, 0);
        tick();
        check("ihit_done", done, 1);
        tick();

        // D_Hit_Writeback_Invalid dirty hit in way 0; early wb_done during CHECK is ignored
        request(D_Hit_Writeback_Invalid, 8'h10, 2'd2, 20'h00400, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        #1;
        check("dwb_wbreq_t1", wb_req, 0);
        tick();
        wb_done = 1'b1;
        check("dwb_wbreq_t2", wb_req, 0);
        tick();
        wb_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("dwb_wb_req", wb_req, 1);
            check("dwb_wb_addr", wb_addr, 32'h00400100);
            check("dwb_wb_way", wb_way, 0);
            check("dwb_we_hold", tag_we, 0);
            check("dwb_done_hold", done, 0);
            if (i == 4) wb_done = 1'b1;
            tick();
        end
        wb_done = 1'b0;
        #1;
        check("dwb_wbreq_drop", wb_req, 0);
        check("dwb_we", tag_we, 4'b0001);
        check("dwb_wdata", tag_wdata, 0);
        tick();
        check("dwb_done", done, 1);
        tick();

        // D_Hit_Invalid miss (only an invalid way carries the tag)
        request(D_Hit_Invalid, 8'h20, 2'd2, 20'h77777, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        #1;
        check("miss_we_t1", tag_we, 0);
        tick();
        check("miss_we_t2", tag_we, 0);
        check("miss_wbreq_t2", wb_req, 0);
        tick();
        check("miss_done", done, 1);
        check("miss_we_t3", tag_we, 0);
        check("miss_wbreq_t3", wb_req, 0);
        tick();
        check("miss_ready", req_ready, 1);

        // D_Index_Writeback_Invalid on clean way 1 (way 0 dirty as decoy)
        request(D_Index_Writeback_Invalid, 8'h30, 2'd1, 20'h00000, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        #1;
        check("iwb_wbreq_t1", wb_req, 0);
        tick();
        check("iwb_wbreq_t2", wb_req, 0);
        tick();
        check("iwb_we", tag_we, 4'b0010);
        check("iwb_wdata", tag_wdata, 0);
        check("iwb_wbreq_t3", wb_req, 0);
        tick();
        check("iwb_done", done, 1);
        tick();

        // Dirty Index writeback, then reset while in WRITEBACK
        request(D_Index_Writeback_Invalid, 8'h40, 2'd3, 20'h00000, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("rwb_wb_req", wb_req, 1);
        check("rwb_wb_addr", wb_addr, 32'hCAFE0400);
        check("rwb_wb_way", wb_way, 3);
        tick();
        check("rwb_still_wb", wb_req, 1);
        reset = 1'b1;
        #1;
        check("rwb_abort_wbreq", wb_req, 0);
        check("rwb_abort_busy", busy, 0);
        check("rwb_abort_ready", req_ready, 1);
        check("rwb_abort_done", done, 0);
        tick();
        check("rwb_rst_done", done, 0);
        check("rwb_rst_we", tag_we, 0);
        reset = 1'b0;
        tick();

        // Unrecognised op after reset: accepted, retires next cycle with no RAM access
        request(I_Index_Load_Tag, 8'h77, 2'd1, 20'h00001, 1'b0, 1'b0);
        check("unk_accept_busy", busy, 1);
        check("unk_accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
        check("unk_done", done, 1);
        check("unk_we", tag_we, 0);
        check("unk_wbreq", wb_req, 0);
        tick();
        check("unk_ready", req_ready, 1);
        check("unk_done_low", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
